// File: rtl/divider_int8_seq.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Valid/ready handshakes on both sides; a zero divisor short-circuits to a flagged result.
module divider_int8_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   divisor_reg;
    logic [WIDTH-1:0]   q_work_reg;
    logic [WIDTH:0]     rem_work_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               dbz_reg;

    logic               accept;
    logic               last_iter;
    logic               trial_ok;
    logic [WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   q_next;

    assign accept    = in_valid && (state_reg == IDLE);
    assign last_iter = (count_reg == CNT_W'(WIDTH - 1));

    // One restoring step: the sign of the trial difference decides the quotient bit.
    assign shifted  = {rem_work_reg, q_work_reg[WIDTH-1]};
    assign trial    = shifted - {2'b00, divisor_reg};
    assign trial_ok = !trial[WIDTH+1];
    assign rem_next = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
    assign q_next   = {q_work_reg[WIDTH-2:0], trial_ok};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_reg   <= '0;
            q_work_reg    <= '0;
            rem_work_reg  <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            divisor_reg  <= divisor;
                            q_work_reg   <= dividend;
                            rem_work_reg <= '0;
                            count_reg    <= '0;
                        end
                    end
                end
                CALC: begin
                    rem_work_reg <= rem_next;
                    q_work_reg   <= q_next;
                    count_reg    <= count_reg + CNT_W'(1);
                    if (last_iter) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= rem_next[WIDTH-1:0];
                        dbz_reg       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
endmodule

// File: doc/divider_int8_seq.md
Name: divider_int8_seq

Overview:
- Sequential unsigned integer divider; the inverse of the combinational int8 multiplier.
- Computes quotient and remainder of an 8-bit dividend by an 8-bit divisor using restoring division, one quotient bit per clock.
- Uses valid/ready handshakes on both input and output, so it can sit behind an operand source and in front of a result consumer with backpressure.
- Results must satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor; this is checkable against the multiplier.

Parameters:
- WIDTH, 8, operand/result bit width. All tests use 8. The design must stay correct for any WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  dividend/divisor presented
- in_ready  output  1  divider can accept operands
- dividend  input  WIDTH  unsigned dividend, sampled on input handshake only
- divisor  input  WIDTH  unsigned divisor, sampled on input handshake only
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  result corresponds to divisor == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset takes effect immediately, including mid-CALC or in DONE; any in-flight operation is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- in_ready is decoded from state (state==IDLE) only; it has no combinational path from in_valid.
- IDLE -> CALC: at an edge with in_valid && in_ready and divisor != 0.
  - Latch divisor.
  - Working quotient register <= dividend.
  - Partial remainder (WIDTH+1 bits) <= 0.
  - Counter <= 0.
- IDLE -> DONE (divide by zero): at an edge with in_valid && in_ready and divisor == 0.
  - quotient <= all ones (8'hFF).
  - remainder <= dividend.
  - div_by_zero <= 1.
  - out_valid is high in the cycle after the handshake edge.
- CALC iteration (each edge):
  - Shift {rem, q} left by 1 and trial-subtract the divisor from the upper WIDTH+1 bits.
  - If the result is non-negative, keep it and set q LSB=1; otherwise restore and set q LSB=0.
  - Counter increments.
  - After the WIDTH-th iteration, go to DONE with quotient/remainder outputs loaded and div_by_zero=0.
- Latency, nonzero divisor: out_valid rises exactly WIDTH cycles after the input handshake edge (8 cycles for WIDTH=8).
- DONE -> IDLE: at an edge with out_valid && out_ready. in_ready returns the next cycle, so there is no same-cycle turnaround and the maximum throughput is one result per WIDTH+2 cycles.
- Backpressure: while out_valid && !out_ready, quotient, remainder and div_by_zero hold stable, and no new input is accepted.
- Output registers keep their last values in IDLE/CALC. Consumers must qualify with out_valid.
- Changes on dividend/divisor/in_valid outside the IDLE handshake are ignored.
- out_ready is ignored unless out_valid=1.
- Boundary cases:
  - dividend < divisor -> q=0, r=dividend.
  - dividend == divisor -> q=1, r=0.
  - divisor=1 -> q=dividend, r=0.
  - 255/255 -> q=1, r=0.
  - 0/x -> q=0, r=0.
- No X on any output after reset is released.

Test Plan:
- Reset then 25/5, out_ready=1 -> in_ready drops the cycle after the handshake; out_valid high exactly 8 cycles after the handshake edge with q=5, r=0, dbz=0; in_ready high again the cycle after out handshake.
- Sweep 200/7, 255/1, 3/10, 255/255, 0/9 -> (28,4), (255,0), (0,3), (1,0), (0,0). For each result, check q*divisor+r==dividend with multiplier_int8 (low 8 bits) plus a bench-side check.
- 5/0 -> out_valid in the cycle after the handshake; q=8'hFF, r=5, dbz=1. A following 10/3 -> q=3, r=1, dbz=0.
- 100/9 with out_ready held low for 5 cycles after out_valid rises -> q=11, r=1 held stable and in_ready=0 throughout; when out_ready is raised, one handshake occurs and then IDLE.
- Start 250/3, then deassert rst_n asynchronously at CALC iteration 4 (mid-cycle) -> all outputs zero immediately and in_ready=1. After release, 250/3 yields q=83, r=1 with no residue from the aborted operation.
- Change dividend/divisor to 1/1 during CALC of 77/4 -> result still q=19, r=1.
